// File: rtl/tick_pwm_pkg.sv
// Shared types and constants for the tick-driven PWM generator.
// Holds the FSM state encoding and the default counter width.
package tick_pwm_pkg;

   localparam int TICK_PWM_CNT_W = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/tick_pwm_gen.sv
// Tick-driven PWM generator. Period and duty are counted in divider ticks and are
// latched into shadow registers only at period boundaries, so the output never glitches.
module tick_pwm_gen
   import tick_pwm_pkg::*;
#(
   parameter int CNT_W = TICK_PWM_CNT_W
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             tick_i,
   input  logic             en_i,
   input  logic [CNT_W-1:0] period_i,
   input  logic [CNT_W-1:0] duty_i,
   output logic             pwm_o,
   output logic             period_end_o,
   output logic             active_o,
   output logic             state_dbg
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] ph_q, ph_d;
   logic [CNT_W-1:0] per_q, per_d;
   logic [CNT_W-1:0] duty_q, duty_d;
   logic             pwm_q, pwm_d;
   logic             pend_q, pend_d;
   logic [CNT_W-1:0] ph_inc;
   logic             at_boundary;
   logic             start_ok;

   // ph stays below per_sh-1 whenever it is incremented, so ph_inc never wraps.
   assign ph_inc      = ph_q + CNT_W'(1);
   assign at_boundary = (ph_q == (per_q - CNT_W'(1)));
   assign start_ok    = en_i && (period_i != '0);

   always_comb begin
      state_d = state_q;
      ph_d    = ph_q;
      per_d   = per_q;
      duty_d  = duty_q;
      pwm_d   = pwm_q;
      pend_d  = 1'b0;
      if (tick_i) begin
         case (state_q)
            ST_IDLE: begin
               if (start_ok) begin
                  per_d   = period_i;
                  duty_d  = duty_i;
                  ph_d    = '0;
                  pwm_d   = (duty_i != '0);
                  state_d = ST_RUN;
               end else begin
                  pwm_d = 1'b0;
               end
            end
            ST_RUN: begin
               if (at_boundary) begin
                  // en_i is only looked at here, which gives the graceful stop.
                  pend_d = 1'b1;
                  ph_d   = '0;
                  if (!start_ok) begin
                     pwm_d   = 1'b0;
                     state_d = ST_IDLE;
                  end else begin
                     per_d  = period_i;
                     duty_d = duty_i;
                     pwm_d  = (duty_i != '0);
                  end
               end else begin
                  ph_d  = ph_inc;
                  pwm_d = (ph_inc < duty_q);
               end
            end
            default: begin
               state_d = ST_IDLE;
               pwm_d   = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q <= ST_IDLE;
         ph_q    <= '0;
         per_q   <= '0;
         duty_q  <= '0;
         pwm_q   <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ph_q    <= ph_d;
         per_q   <= per_d;
         duty_q  <= duty_d;
         pwm_q   <= pwm_d;
         pend_q  <= pend_d;
      end
   end

   assign pwm_o        = pwm_q;
   assign period_end_o = pend_q;
   assign active_o     = (state_q == ST_RUN);
   assign state_dbg    = state_q;

endmodule

// File: tb/tb_tick_pwm_gen.sv
// Directed bench for tick_pwm_gen: hand-computed per-tick waveforms for pwm_o,
// period_end_o and active_o across shadow update, duty extremes, stop and reset cases.
module tb_tick_pwm_gen;
   import tick_pwm_pkg::*;

   localparam int CNT_W = TICK_PWM_CNT_W;

   logic             sys_clk;
   logic             sys_rst;
   logic             tick_i;
   logic             en_i;
   logic [CNT_W-1:0] period_i;
   logic [CNT_W-1:0] duty_i;
   logic             pwm_o;
   logic             period_end_o;
   logic             active_o;
   logic             state_dbg;

   int n_checks;
   int n_fail;

   tick_pwm_gen #(.CNT_W(CNT_W)) dut (
      .sys_clk      (sys_clk),
      .sys_rst      (sys_rst),
      .tick_i       (tick_i),
      .en_i         (en_i),
      .period_i     (period_i),
      .duty_i       (duty_i),
      .pwm_o        (pwm_o),
      .period_end_o (period_end_o),
      .active_o     (active_o),
      .state_dbg    (state_dbg)
   );

   // clock / reset
   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // One tick per gap clocks; bit i of each mask is the expected output after tick i.
   task automatic run_ticks(input string tag, input int n, input logic [15:0] e_pwm,
                            input logic [15:0] e_pend, input logic [15:0] e_act,
                            input int gap);
      for (int i = 0; i < n; i++) begin
         tick_i = 1'b1;
         @(negedge sys_clk);
         tick_i = 1'b0;
         check($sformatf("%s[%0d] pwm", tag, i), 32'(pwm_o), 32'(e_pwm[i]));
         check($sformatf("%s[%0d] pend", tag, i), 32'(period_end_o), 32'(e_pend[i]));
         check($sformatf("%s[%0d] act", tag, i), 32'(active_o), 32'(e_act[i]));
         @(negedge sys_clk);
         check($sformatf("%s[%0d] pend_clr", tag, i), 32'(period_end_o), 32'd0);
         check($sformatf("%s[%0d] pwm_hold", tag, i), 32'(pwm_o), 32'(e_pwm[i]));
         repeat (gap - 2) @(negedge sys_clk);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      sys_rst  = 1'b1;
      tick_i   = 1'b0;
      en_i     = 1'b0;
      period_i = '0;
      duty_i   = '0;
      repeat (2) @(negedge sys_clk);
      check("rst pwm", 32'(pwm_o), 32'd0);
      check("rst pend", 32'(period_end_o), 32'd0);
      check("rst act", 32'(active_o), 32'd0);
      check("rst state", 32'(state_dbg), 32'(ST_IDLE));
      sys_rst = 1'b0;
      @(negedge sys_clk);

      // basic: period 5, duty 2, tick every 4 clocks
      en_i = 1'b1; period_i = 8'd5; duty_i = 8'd2;
      run_ticks("basic", 11, 16'b10001100011, 16'b10000100000, 16'h07ff, 4);

      // duty change at phase 1 only shows after the boundary
      run_ticks("upd_pre", 1, 16'b1, 16'b0, 16'b1, 4);
      duty_i = 8'd4;
      run_ticks("upd", 9, 16'b101111000, 16'b100001000, 16'h01ff, 4);

      // duty above period: 100 % from the next period on
      duty_i = 8'd9;
      run_ticks("duty9", 10, 16'b1111110111, 16'b1000010000, 16'h03ff, 4);

      // duty 0: low from the next period, boundaries still pulse
      duty_i = 8'd0;
      run_ticks("duty0", 10, 16'b0000001111, 16'b1000010000, 16'h03ff, 4);

      // en dropped then re-asserted before the boundary: no stop
      duty_i = 8'd2;
      run_ticks("cancel_a", 1, 16'b0, 16'b0, 16'b1, 4);
      en_i = 1'b0;
      run_ticks("cancel_b", 2, 16'b00, 16'b00, 16'b11, 4);
      en_i = 1'b1;
      run_ticks("cancel_c", 2, 16'b10, 16'b10, 16'b11, 4);

      // graceful stop: en dropped at phase 1
      run_ticks("stop_a", 1, 16'b1, 16'b0, 16'b1, 4);
      en_i = 1'b0;
      run_ticks("stop_b", 6, 16'b000000, 16'b001000, 16'b000111, 4);

      // period 0 with en high keeps the block idle
      en_i = 1'b1; period_i = 8'd0; duty_i = 8'd3;
      run_ticks("per0", 3, 16'b000, 16'b000, 16'b000, 4);

      // continuous tick: period 3, duty 1
      period_i = 8'd3; duty_i = 8'd1;
      tick_i = 1'b1;
      for (int i = 0; i < 9; i++) begin
         @(negedge sys_clk);
         check($sformatf("cont[%0d] pwm", i), 32'(pwm_o), 32'((i % 3) == 0));
         check($sformatf("cont[%0d] pend", i), 32'(period_end_o),
               32'(((i % 3) == 0) && (i > 0)));
         check($sformatf("cont[%0d] act", i), 32'(active_o), 32'd1);
      end
      en_i = 1'b0;
      @(negedge sys_clk);
      tick_i = 1'b0;
      check("cont_stop pend", 32'(period_end_o), 32'd1);
      check("cont_stop pwm", 32'(pwm_o), 32'd0);
      check("cont_stop act", 32'(active_o), 32'd0);
      check("cont_stop state", 32'(state_dbg), 32'(ST_IDLE));
      @(negedge sys_clk);

      // async reset mid-run with pwm high at ph 3
      en_i = 1'b1; period_i = 8'd5; duty_i = 8'd5;
      run_ticks("rst_pre", 4, 16'b1111, 16'b0000, 16'b1111, 4);
      #2 sys_rst = 1'b1;
      #1;
      check("arst pwm", 32'(pwm_o), 32'd0);
      check("arst act", 32'(active_o), 32'd0);
      check("arst pend", 32'(period_end_o), 32'd0);
      @(negedge sys_clk);
      sys_rst = 1'b0;
      @(negedge sys_clk);
      // restart from ph 0: the boundary must be the fifth tick after entry
      run_ticks("rst_post", 6, 16'b111111, 16'b100000, 16'b111111, 4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tick_pwm_gen.md
# tick_pwm_gen

Tick-driven PWM generator that consumes the one-cycle strobe of the programmable clock divider and produces a PWM waveform whose period and duty are counted in divider ticks. Period and duty are shadow-registered and take effect only at period boundaries, so switch or software changes never cause glitches. A disable request completes the current period before the block stops. The block sits directly downstream of the divider, driving a GPIO pin or LED.

## Interface
- CNT_W, 8: width of the period, duty and phase counters.
- sys_clk  in  1  system clock; all logic is on the rising edge.
- sys_rst  in  1  asynchronous reset, active-high.
- tick_i  in  1  one-cycle advance strobe from the divider; may be held high continuously.
- en_i  in  1  run request, level-sensitive.
- period_i  in  CNT_W  PWM period in ticks; 0 means disabled.
- duty_i  in  CNT_W  number of high ticks per period; values ≥ period give 100 %.
- pwm_o  out  1  PWM output, registered.
- period_end_o  out  1  one-cycle pulse on each completed period, registered.
- active_o  out  1  high while in RUN, registered.

## Operation
- FSM states are IDLE and RUN. Internal state: ph (CNT_W bits), per_sh and duty_sh (CNT_W bits each).
- Nothing changes on a cycle where tick_i=0, except the period_end_o clear.
- IDLE:
  - On tick_i=1 with en_i=1 and period_i≠0: per_sh←period_i, duty_sh←duty_i, ph←0, pwm_o←(duty_i≠0), move to RUN.
  - Otherwise pwm_o=0 and period_i/duty_i are ignored.
- RUN, on tick_i=1 with ph≠per_sh−1: ph←ph+1, pwm_o←(ph+1 < duty_sh).
- RUN, on tick_i=1 with ph=per_sh−1 (boundary):
  - period_end_o←1 and ph←0.
  - If en_i=0 or period_i=0: pwm_o←0 and go to IDLE.
  - Otherwise reload per_sh←period_i and duty_sh←duty_i, and set pwm_o←(duty_i≠0).
- en_i deasserted mid-period has no effect until the boundary (graceful stop). Re-asserting it before the boundary cancels the stop.
- period_i and duty_i changes mid-period are invisible until the next boundary.
- period_end_o is high for exactly one cycle per boundary and is cleared on every other cycle.
- Comparisons are unsigned at CNT_W width. ph never exceeds per_sh−1, so no wrap logic is needed. Maximum period is 2^CNT_W−1 ticks.

## Timing
- Reset values: pwm_o=0, period_end_o=0, active_o=0, state=IDLE, ph=0, per_sh=0, duty_sh=0.
- Reset asserted mid-period clears all outputs immediately (asynchronous). After release the block restarts from IDLE on the next qualifying tick.
- Latency: every output changes on the sys_clk edge that samples tick_i=1, so there is one cycle from tick to output.
- High time is exactly min(duty_sh, per_sh) ticks; period is exactly per_sh ticks.
- With tick_i held high, the block advances every cycle: period = per_sh clocks, and boundaries come back-to-back.
- active_o rises on the edge entering RUN and falls on the edge of the final boundary.

## Structure
- Package tick_pwm_pkg holds the state enum (ST_IDLE, ST_RUN) and the default CNT_W constant.
- No sub-module. The phase counter, shadow registers and FSM are a single always block plus the output registers.
- Top-level integration:
  - tick_i connects to the divider strobe.
  - period_i and duty_i come from switches or registers; this block does not synchronise them.

## Test plan
- Basic waveform:
  - Stimulus: period=5, duty=2, en=1, tick every 4 clocks.
  - Response: pwm high 2 ticks / low 3 ticks repeating; period_end_o pulses every 20 clocks.
- Boundary-only update:
  - Stimulus: duty changed 2→4 at phase 1.
  - Response: the current period keeps 2 high ticks; the next period has 4 high ticks, with no glitch.
- Duty extremes:
  - duty=0 → pwm_o stays 0 and period_end_o still pulses.
  - duty=9 with period=5 → pwm_o stays 1.
  - period=0 while en=1 → the block stays in IDLE and active_o=0.
- Graceful stop:
  - Stimulus: en dropped at phase 1 of period=5.
  - Response: the period finishes, period_end_o pulses once, then active_o=0 and pwm_o=0.
  - Stimulus: en re-asserted before the boundary.
  - Response: running continues uninterrupted.
- Continuous tick:
  - Stimulus: tick_i held at 1, period=3, duty=1.
  - Response: pwm_o pattern 1,0,0 repeating every cycle; period_end_o on every third cycle.
- Async reset mid-run:
  - Stimulus: sys_rst pulsed while pwm_o=1 and ph=3.
  - Response: outputs go to 0 before the next edge; after release the block restarts at ph=0 on the first tick.
